// File: rtl/id_pipe_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, function codes, ALU operation/result encodings.
package id_pipe_stage_pkg;

  localparam int ALUOP_W_DEF  = 8;
  localparam int ALUSEL_W_DEF = 3;

  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        ReadEna    = 1'b1;
  localparam logic        WriteEna   = 1'b1;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'b000000,
    OP_ANDI    = 6'b001100,
    OP_ORI     = 6'b001101,
    OP_XORI    = 6'b001110,
    OP_LUI     = 6'b001111,
    OP_PREF    = 6'b110011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_SLLV = 6'b000100,
    FN_SRLV = 6'b000110,
    FN_SRAV = 6'b000111,
    FN_SYNC = 6'b001111,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_NOR  = 6'b100111
  } funct_e;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP = 8'b0000_0111;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

endpackage

// File: rtl/id_pipe_stage_decode.sv
// Combinational instruction decoder for the logic/shift subset; produces control and per-operand immediates.
module id_decode
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = ALUOP_W_DEF,
  parameter int ALUSEL_W = ALUSEL_W_DEF
) (
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  output logic                wreg_o,
  output logic [REG_AW-1:0]   waddr_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   imm1_o,
  output logic [DATA_W-1:0]   imm2_o,
  output logic                illegal_o
);

  logic [REG_AW-1:0] rt, rd;

  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign rt          = REG_AW'(inst_i[20:16]);
  assign rd          = REG_AW'(inst_i[15:11]);

  always_comb begin
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    wreg_o      = 1'b0;
    waddr_o     = REG_AW'(NOPRegAddr);
    aluop_o     = ALUOP_W'(EXE_NOP_OP);
    alusel_o    = ALUSEL_W'(EXE_RES_NOP);
    imm1_o      = '0;
    imm2_o      = '0;
    illegal_o   = 1'b0;
    case (opcode_e'(inst_i[31:26]))
      OP_ANDI, OP_ORI, OP_XORI: begin
        reg1_read_o = ReadEna;
        imm2_o      = DATA_W'(inst_i[15:0]);
        wreg_o      = WriteEna;
        waddr_o     = rt;
        alusel_o    = ALUSEL_W'(EXE_RES_LOGIC);
        aluop_o     = (inst_i[27:26] == 2'b00) ? ALUOP_W'(EXE_AND_OP) :
                      (inst_i[27:26] == 2'b01) ? ALUOP_W'(EXE_OR_OP)  : ALUOP_W'(EXE_XOR_OP);
      end
      // LUI is issued as 0 | (imm << 16) so EX needs no dedicated operation
      OP_LUI: begin
        imm2_o   = DATA_W'({inst_i[15:0], 16'h0000});
        wreg_o   = WriteEna;
        waddr_o  = rt;
        alusel_o = ALUSEL_W'(EXE_RES_LOGIC);
        aluop_o  = ALUOP_W'(EXE_OR_OP);
      end
      OP_PREF: ;
      OP_SPECIAL: begin
        case (funct_e'(inst_i[5:0]))
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV: begin
            reg1_read_o = ReadEna;
            reg2_read_o = ReadEna;
            wreg_o      = WriteEna;
            waddr_o     = rd;
            alusel_o    = inst_i[5] ? ALUSEL_W'(EXE_RES_LOGIC) : ALUSEL_W'(EXE_RES_SHIFT);
            aluop_o     = ALUOP_W'({2'b00, inst_i[5:0]});
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            if (inst_i[25:21] == 5'd0) begin
              reg2_read_o = ReadEna;
              imm1_o      = DATA_W'(inst_i[10:6]);
              wreg_o      = WriteEna;
              waddr_o     = rd;
              alusel_o    = ALUSEL_W'(EXE_RES_SHIFT);
              aluop_o     = (inst_i[1:0] == 2'b00) ? ALUOP_W'(EXE_SLL_OP) : ALUOP_W'({2'b00, inst_i[5:0]});
            end else begin
              illegal_o = 1'b1;
            end
          end
          FN_SYNC: ;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_pipe_stage.sv
// ID stage with operand bypass, load-use stall and ID/EX register.
// Optional ID_STALL_CNT_EN adds a saturating stall-cycle counter output.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             pc_i,
  input  logic [31:0]                   inst_i,
  output logic                          reg1_read_o,
  output logic                          reg2_read_o,
  output logic [REG_AW-1:0]             reg1_addr_o,
  output logic [REG_AW-1:0]             reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_wreg_i,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_waddr_i,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_wdata_i,
  input  logic [FWD_PORTS-1:0]          fwd_pending_i,
  input  logic                          flush_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             pc_o,
  output logic [ALUOP_W-1:0]            aluop_o,
  output logic [ALUSEL_W-1:0]           alusel_o,
  output logic [DATA_W-1:0]             reg1_o,
  output logic [DATA_W-1:0]             reg2_o,
  output logic                          wreg_o,
  output logic [REG_AW-1:0]             waddr_o,
  output logic                          illegal_o,
  output logic                          stall_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              pend;
  } opnd_t;

  logic                wreg_d, illegal_d;
  logic [REG_AW-1:0]   waddr_d;
  logic [ALUOP_W-1:0]  aluop_d;
  logic [ALUSEL_W-1:0] alusel_d;
  logic [DATA_W-1:0]   imm1, imm2;
  opnd_t               op1, op2;
  logic                accept;

  logic                valid_q, wreg_q, illegal_q;
  logic [DATA_W-1:0]   pc_q, reg1_q, reg2_q;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [ALUSEL_W-1:0] alusel_q;
  logic [REG_AW-1:0]   waddr_q;

  id_decode #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .ALUOP_W (ALUOP_W),
    .ALUSEL_W(ALUSEL_W)
  ) u_decode (
    .inst_i     (inst_i),
    .reg1_read_o(reg1_read_o),
    .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o),
    .reg2_addr_o(reg2_addr_o),
    .wreg_o     (wreg_d),
    .waddr_o    (waddr_d),
    .aluop_o    (aluop_d),
    .alusel_o   (alusel_d),
    .imm1_o     (imm1),
    .imm2_o     (imm2),
    .illegal_o  (illegal_d)
  );

  // Only the highest-priority matching source decides pending, so a fresh
  // younger result hides an older outstanding load to the same register.
  function automatic opnd_t resolve(input logic rd_en, input logic [REG_AW-1:0] addr,
                                    input logic [DATA_W-1:0] rf, input logic [DATA_W-1:0] imm);
    opnd_t r;
    logic  hit;
    r.val  = imm;
    r.pend = 1'b0;
    hit    = 1'b0;
    if (rd_en) begin
      if (addr == '0) begin
        r.val = '0;
      end else begin
        r.val = rf;
        for (int unsigned i = 0; i < FWD_PORTS; i++) begin
          if (!hit && fwd_wreg_i[i] && fwd_waddr_i[i*REG_AW +: REG_AW] == addr) begin
            hit    = 1'b1;
            r.val  = fwd_wdata_i[i*DATA_W +: DATA_W];
            r.pend = fwd_pending_i[i];
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(reg1_read_o, reg1_addr_o, reg1_data_i, imm1);
    op2 = resolve(reg2_read_o, reg2_addr_o, reg2_data_i, imm2);
  end

  assign stall_o  = in_valid && (op1.pend || op2.pend);
  assign in_ready = !stall_o && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      aluop_q   <= ALUOP_W'(EXE_NOP_OP);
      alusel_q  <= ALUSEL_W'(EXE_RES_NOP);
      reg1_q    <= '0;
      reg2_q    <= '0;
      wreg_q    <= 1'b0;
      waddr_q   <= REG_AW'(NOPRegAddr);
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= pc_i;
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= op1.val;
      reg2_q    <= op2.val;
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      illegal_q <= illegal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign pc_o      = pc_q;
  assign aluop_o   = aluop_q;
  assign alusel_o  = alusel_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign wreg_o    = wreg_q;
  assign waddr_o   = waddr_q;
  assign illegal_o = illegal_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_o && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
